sum_accumulator: RTL

//  Downstream consumer of the combinational 32-bit adder: registers each sum Y offered on a

---
 rtl/sum_accumulator.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/sum_accumulator.sv
// Purpose: accumulates COUNT unsigned adder sums into an ACC_WIDTH total with a sticky carry flag.
// Latency: out_valid rises the cycle after the closing accept or flush; all outputs are registered.
// Backpressure: in_ready drops while a result is held; input resumes the cycle after the output handshake.
//
// Ports:
//   clk, rst                  single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready/in_data input sample stream (unsigned sum Y from the adder)
//   flush                     1-cycle pulse that closes a partially filled block
//   out_valid/out_ready       result handshake
//   out_data/out_count/out_ovf block total (wrapping), samples in block, carry-out seen in block

module sum_accumulator #(
    parameter int WIDTH     = 32,   // incoming sum width
    parameter int ACC_WIDTH = 40,   // accumulator width, must be >= WIDTH
    parameter int COUNT     = 4     // samples per block, must be >= 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    input  logic                         flush,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_WIDTH-1:0]         out_data,
    output logic [$clog2(COUNT+1)-1:0]   out_count,
    output logic                         out_ovf
);

    localparam int              CW      = $clog2(COUNT + 1);
    localparam logic [CW-1:0]   COUNT_C = CW'(COUNT);
    localparam logic [CW-1:0]   ONE_C   = CW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                 state_q,     state_d;
    logic [ACC_WIDTH-1:0]   acc_q,       acc_d;
    logic [CW-1:0]          cnt_q,       cnt_d;
    logic                   ovf_q,       ovf_d;

    logic                   in_ready_q,  in_ready_d;
    logic                   out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0]   out_data_q,  out_data_d;
    logic [CW-1:0]          out_count_q, out_count_d;
    logic                   out_ovf_q,   out_ovf_d;

    // ------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------
    logic                   accept;
    logic [ACC_WIDTH-1:0]   in_ext;
    logic [ACC_WIDTH:0]     sum_full;   // one extra bit to catch the carry out
    logic [CW-1:0]          cnt_inc;

    assign accept   = in_valid & in_ready_q;
    assign in_ext   = ACC_WIDTH'(in_data);
    assign sum_full = {1'b0, acc_q} + {1'b0, in_ext};
    assign cnt_inc  = cnt_q + ONE_C;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        logic close_blk;

        close_blk   = 1'b0;
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_ovf_d   = out_ovf_q;

        case (state_q)
            IDLE: begin
                // First sample of a block loads rather than adds, so no residue
                // from a previous block can leak in. A flush here has nothing
                // to close and is dropped.
                if (accept) begin
                    acc_d     = in_ext;
                    cnt_d     = ONE_C;
                    ovf_d     = 1'b0;
                    state_d   = ACCUM;
                    close_blk = (COUNT == 1);
                end
            end

            ACCUM: begin
                if (accept) begin
                    acc_d     = sum_full[ACC_WIDTH-1:0];
                    cnt_d     = cnt_inc;
                    ovf_d     = ovf_q | sum_full[ACC_WIDTH];
                    // A flush coinciding with an accept closes the block
                    // with that sample included.
                    close_blk = (cnt_inc == COUNT_C) || flush;
                end else if (flush) begin
                    close_blk = 1'b1;
                end
            end

            HOLD: begin
                // Result stays frozen until taken; flush has no effect here.
                if (out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end

            default: begin
                state_d     = IDLE;
                acc_d       = '0;
                cnt_d       = '0;
                ovf_d       = 1'b0;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Closing a block snapshots the updated totals into the output
        // registers, so the result appears one cycle after the closing event.
        if (close_blk) begin
            state_d     = HOLD;
            out_data_d  = acc_d;
            out_count_d = cnt_d;
            out_ovf_d   = ovf_d;
            out_valid_d = 1'b1;
            in_ready_d  = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_ovf   = out_ovf_q;

endmodule
